// File: rtl/asp_hostmem_arbiter.sv
// asp_hostmem_arbiter: round-robin arbiter sharing one Avalon-MM host-memory
// channel between NUM_REQ requesters. Writes may hold the channel for a whole
// burst; reads are tracked in an order FIFO so returning beats can be routed
// back to the requester that issued them.
// Optional feature macro: ASP_HOSTMEM_ARB_PERF_CNT_EN adds the grant_count
// output (one 32-bit wrapping counter per requester).
module asp_hostmem_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 512,
  parameter int BURST_W   = 6,
  parameter int RSP_DEPTH = 16
) (
  input  logic                          pClk,
  input  logic                          pClk_reset,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
  input  logic [NUM_REQ*BURST_W-1:0]    req_burstcount,
  input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [DATA_W-1:0]             req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  output logic                          m_read,
  output logic                          m_write,
  output logic [ADDR_W-1:0]             m_address,
  output logic [BURST_W-1:0]            m_burstcount,
  output logic [DATA_W-1:0]             m_writedata,
  output logic [DATA_W/8-1:0]           m_byteenable,
  input  logic                          m_waitrequest,
  input  logic [DATA_W-1:0]             m_readdata,
  input  logic                          m_readdatavalid,
  output logic                          rsp_err
`ifdef ASP_HOSTMEM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]         grant_count
`endif
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [0:0] {ARB = 1'b0, WR_BURST = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [ID_W-1:0]      rr_ptr_r, rr_ptr_s;
  logic [ID_W-1:0]      lock_id_r, lock_id_s;
  logic [BURST_W-1:0]   beat_cnt_r, beat_cnt_s;
  logic [ID_W-1:0]      arb_id_s, gnt_id_s;
  logic                 arb_found_s;
  logic                 accept_s;
  logic                 push_s, pop_s, rsp_hit_s;

  // Read-order FIFO: requester id and burst length of every accepted read.
  logic [ID_W-1:0]      fifo_id_mem [RSP_DEPTH];
  logic [BURST_W-1:0]   fifo_len_mem [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]       fifo_cnt_r;
  logic                 fifo_full_s, fifo_empty_s;
  logic [ID_W-1:0]      head_id_s;
  logic [BURST_W-1:0]   head_len_s;
  logic [BURST_W-1:0]   rsp_beat_r;
  logic                 rsp_err_r;

  // Round-robin successor of a requester id.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      next_id = {ID_W{1'b0}};
    end else begin
      next_id = id + ID_W'(1'b1);
    end
  endfunction

  assign fifo_full_s  = (fifo_cnt_r == (PTR_W + 1)'(RSP_DEPTH));
  assign fifo_empty_s = (fifo_cnt_r == {(PTR_W + 1){1'b0}});
  assign head_id_s    = fifo_id_mem[rd_ptr_r];
  assign head_len_s   = fifo_len_mem[rd_ptr_r];

  // Find the first eligible requester at or after rr_ptr_r; a full order FIFO makes reads ineligible.
  always_comb begin
    logic [ID_W:0] cand_v;
    arb_found_s = 1'b0;
    arb_id_s    = rr_ptr_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_v = {1'b0, rr_ptr_r} + (ID_W + 1)'(i);
      if (cand_v >= (ID_W + 1)'(NUM_REQ)) begin
        cand_v = cand_v - (ID_W + 1)'(NUM_REQ);
      end else begin
        cand_v = cand_v;
      end
      if (!arb_found_s && (req_write[cand_v[ID_W-1:0]] ||
                           (req_read[cand_v[ID_W-1:0]] && !fifo_full_s))) begin
        arb_found_s = 1'b1;
        arb_id_s    = cand_v[ID_W-1:0];
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Select the granted requester and its command strobes; a write burst locks the grant and blocks reads.
  always_comb begin
    gnt_id_s = arb_id_s;
    m_read   = 1'b0;
    m_write  = 1'b0;
    case (state_r)
      ARB: begin
        gnt_id_s = arb_id_s;
        if (arb_found_s && !pClk_reset) begin
          m_read  = req_read[arb_id_s] & ~fifo_full_s;
          m_write = req_write[arb_id_s];
        end else begin
          m_read  = 1'b0;
          m_write = 1'b0;
        end
      end
      WR_BURST: begin
        gnt_id_s = lock_id_r;
        m_read   = 1'b0;
        if (!pClk_reset) begin
          m_write = req_write[lock_id_r];
        end else begin
          m_write = 1'b0;
        end
      end
      default: begin
        gnt_id_s = arb_id_s;
        m_read   = 1'b0;
        m_write  = 1'b0;
      end
    endcase
  end

  assign m_address    = req_address[gnt_id_s*ADDR_W +: ADDR_W];
  assign m_burstcount = req_burstcount[gnt_id_s*BURST_W +: BURST_W];
  assign m_writedata  = req_writedata[gnt_id_s*DATA_W +: DATA_W];
  assign m_byteenable = req_byteenable[gnt_id_s*BE_W +: BE_W];
  assign accept_s     = (m_read | m_write) & ~m_waitrequest;

  // Next-state logic: pointer advance, burst lock/countdown, FIFO push and requester backpressure.
  always_comb begin
    state_s         = state_r;
    rr_ptr_s        = rr_ptr_r;
    lock_id_s       = lock_id_r;
    beat_cnt_s      = beat_cnt_r;
    push_s          = 1'b0;
    req_waitrequest = {NUM_REQ{1'b1}};
    if (accept_s) begin
      req_waitrequest[gnt_id_s] = 1'b0;
    end else begin
      req_waitrequest = {NUM_REQ{1'b1}};
    end
    case (state_r)
      ARB: begin
        if (accept_s && m_read) begin
          push_s   = 1'b1;
          rr_ptr_s = next_id(gnt_id_s);
        end else if (accept_s && (m_burstcount == BURST_W'(1'b1))) begin
          rr_ptr_s = next_id(gnt_id_s);
        end else if (accept_s) begin
          lock_id_s  = gnt_id_s;
          beat_cnt_s = m_burstcount - BURST_W'(1'b1);
          state_s    = WR_BURST;
        end else begin
          state_s = ARB;
        end
      end
      WR_BURST: begin
        if (accept_s && (beat_cnt_r == BURST_W'(1'b1))) begin
          rr_ptr_s   = next_id(lock_id_r);
          beat_cnt_s = {BURST_W{1'b0}};
          state_s    = ARB;
        end else if (accept_s) begin
          beat_cnt_s = beat_cnt_r - BURST_W'(1'b1);
        end else begin
          state_s = WR_BURST;
        end
      end
      default: state_s = ARB;
    endcase
  end

  // Route each returning beat to the FIFO head's requester; the last beat of the head burst pops it.
  always_comb begin
    req_readdatavalid = {NUM_REQ{1'b0}};
    rsp_hit_s         = m_readdatavalid & ~fifo_empty_s;
    if (rsp_hit_s) begin
      req_readdatavalid[head_id_s] = 1'b1;
      pop_s = ((rsp_beat_r + BURST_W'(1'b1)) == head_len_s);
    end else begin
      pop_s = 1'b0;
    end
  end

  assign req_readdata = m_readdata;
  assign rsp_err      = rsp_err_r;

  // Control state, FIFO pointers, response beat counter and sticky orphan-beat error.
  always_ff @(posedge pClk or posedge pClk_reset) begin
    if (pClk_reset) begin
      state_r    <= ARB;
      rr_ptr_r   <= {ID_W{1'b0}};
      lock_id_r  <= {ID_W{1'b0}};
      beat_cnt_r <= {BURST_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {(PTR_W + 1){1'b0}};
      rsp_beat_r <= {BURST_W{1'b0}};
      rsp_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      lock_id_r  <= lock_id_s;
      beat_cnt_r <= beat_cnt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W + 1)'(1'b1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W + 1)'(1'b1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      if (pop_s) begin
        rsp_beat_r <= {BURST_W{1'b0}};
      end else if (rsp_hit_s) begin
        rsp_beat_r <= rsp_beat_r + BURST_W'(1'b1);
      end
      if (m_readdatavalid && fifo_empty_s) rsp_err_r <= 1'b1;
    end
  end

  // Order FIFO storage; contents are only meaningful between push and pop.
  always_ff @(posedge pClk) begin
    if (push_s) begin
      fifo_id_mem[wr_ptr_r]  <= gnt_id_s;
      fifo_len_mem[wr_ptr_r] <= m_burstcount;
    end
  end

`ifdef ASP_HOSTMEM_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0] credit_s;

  // A grant is credited on an accepted read, a single-beat write or the last beat of a write burst.
  always_comb begin
    credit_s = {NUM_REQ{1'b0}};
    if (accept_s) begin
      case (state_r)
        ARB: begin
          if (m_read || (m_burstcount == BURST_W'(1'b1))) begin
            credit_s[gnt_id_s] = 1'b1;
          end else begin
            credit_s = {NUM_REQ{1'b0}};
          end
        end
        WR_BURST: begin
          if (beat_cnt_r == BURST_W'(1'b1)) begin
            credit_s[gnt_id_s] = 1'b1;
          end else begin
            credit_s = {NUM_REQ{1'b0}};
          end
        end
        default: credit_s = {NUM_REQ{1'b0}};
      endcase
    end else begin
      credit_s = {NUM_REQ{1'b0}};
    end
  end

  // Per-requester wrapping grant counters.
  always_ff @(posedge pClk or posedge pClk_reset) begin
    if (pClk_reset) begin
      grant_count <= {(NUM_REQ * 32){1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (credit_s[i]) grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_asp_hostmem_arbiter.sv
// Directed scoreboard bench for asp_hostmem_arbiter (NUM_REQ=2, RSP_DEPTH=16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_asp_hostmem_arbiter;

  localparam int NR = 2;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int BW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd, wr;
  logic [NR*AW-1:0]  addr;
  logic [NR*BW-1:0]  bc;
  logic [NR*DW-1:0]  wdata;
  logic [NR*DW/8-1:0] be;
  logic [NR-1:0]     waitreq;
  logic [DW-1:0]     rdata_out;
  logic [NR-1:0]     rdv_out;
  logic              m_read, m_write;
  logic [AW-1:0]     m_address;
  logic [BW-1:0]     m_burstcount;
  logic [DW-1:0]     m_writedata;
  logic [DW/8-1:0]   m_byteenable;
  logic              m_wait;
  logic [DW-1:0]     m_rdata;
  logic              m_rdv;
  logic              rsp_err;
`ifdef ASP_HOSTMEM_ARB_PERF_CNT_EN
  logic [NR*32-1:0]  grant_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [NR-1:0] exp_q[$];

  asp_hostmem_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RSP_DEPTH(16)
  ) dut (
    .pClk(clk), .pClk_reset(rst),
    .req_read(rd), .req_write(wr), .req_address(addr), .req_burstcount(bc),
    .req_writedata(wdata), .req_byteenable(be),
    .req_waitrequest(waitreq), .req_readdata(rdata_out), .req_readdatavalid(rdv_out),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_wait), .m_readdata(m_rdata), .m_readdatavalid(m_rdv),
    .rsp_err(rsp_err)
`ifdef ASP_HOSTMEM_ARB_PERF_CNT_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(NR'(2'b01 << id));
  endtask

  // One returned read beat: routing must match the scoreboard head.
  task automatic beat(input string tag, input logic [DW-1:0] data);
    logic [NR-1:0] e;
    m_rdv   = 1'b1;
    m_rdata = data;
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
    check(tag, 64'(rdv_out), 64'(e));
    check({tag, "_data"}, 64'(rdata_out), 64'(data));
    tick();
    m_rdv = 1'b0;
  endtask

  function automatic logic [AW-1:0] addr_of(input int id);
    return (id == 0) ? addr[AW-1:0] : addr[2*AW-1:AW];
  endfunction

  initial begin
    rst    = 1'b1;
    rd     = 2'b11;
    wr     = 2'b00;
    addr   = {48'h0000_1111_0000, 48'h0000_0000_A000};
    bc     = {6'd1, 6'd1};
    wdata  = {64'h1111_0000_0000_0000, 64'h0};
    be     = 16'hFFFF;
    m_wait = 1'b0;
    m_rdata = 64'h0;
    m_rdv  = 1'b0;

    // Reset: no command leaks out even with both requesters reading.
    @(negedge clk);
    check("rst_m_read", 64'(m_read), 64'd0);
    check("rst_m_write", 64'(m_write), 64'd0);
    check("rst_waitreq", 64'(waitreq), 64'(2'b11));
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    tick();
    rst = 1'b0;

    // Continuous single-beat reads from both: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_waitreq", 64'(waitreq), 64'(2'b11 & ~(2'b01 << (k % 2))));
      check("rr_m_read", 64'(m_read), 64'd1);
      check("rr_addr", 64'(m_address), 64'(addr_of(k % 2)));
      push_beats(k % 2, 1);
      tick();
    end
    rd = 2'b00;
    for (int k = 0; k < 4; k++) beat("rr_rsp", 64'hA0 + 64'(k));

    // Req0 burst 3 then req1 burst 2: routing 01,01,01,10,10.
    rd = 2'b01; bc = {6'd1, 6'd3};
    @(negedge clk);
    check("b3_waitreq", 64'(waitreq), 64'(2'b10));
    check("b3_bc", 64'(m_burstcount), 64'd3);
    push_beats(0, 3);
    tick();
    rd = 2'b10; bc = {6'd2, 6'd3};
    @(negedge clk);
    check("b2_waitreq", 64'(waitreq), 64'(2'b01));
    check("b2_bc", 64'(m_burstcount), 64'd2);
    push_beats(1, 2);
    tick();
    rd = 2'b00;
    for (int k = 0; k < 5; k++) beat("burst_rsp", 64'hB0 + 64'(k));
    check("no_err", 64'(rsp_err), 64'd0);

    // Req0 4-beat write holds off req1's read, including across a stall.
    wr = 2'b01; rd = 2'b10; bc = {6'd1, 6'd4};
    for (int b = 0; b < 4; b++) begin
      wdata[DW-1:0] = 64'hD0 + 64'(b);
      if (b == 2) begin
        m_wait = 1'b1;
        @(negedge clk);
        check("wb_stall_waitreq", 64'(waitreq), 64'(2'b11));
        check("wb_stall_m_write", 64'(m_write), 64'd1);
        tick();
        m_wait = 1'b0;
      end
      @(negedge clk);
      check("wb_waitreq", 64'(waitreq), 64'(2'b10));
      check("wb_m_write", 64'(m_write), 64'd1);
      check("wb_m_read", 64'(m_read), 64'd0);
      check("wb_wdata", 64'(m_writedata), 64'hD0 + 64'(b));
      if (b == 0) check("wb_bc", 64'(m_burstcount), 64'd4);
      tick();
    end
    wr = 2'b00;
    @(negedge clk);
    check("after_wb_waitreq", 64'(waitreq), 64'(2'b01));
    check("after_wb_m_read", 64'(m_read), 64'd1);
    push_beats(1, 1);
    tick();
    rd = 2'b00;
    beat("after_wb_rsp", 64'hC0);

    // Sixteen outstanding reads fill the order FIFO.
    rd = 2'b01; bc = {6'd1, 6'd1};
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("fill_waitreq", 64'(waitreq), 64'(2'b10));
      push_beats(0, 1);
      tick();
    end
    @(negedge clk);
    check("full_waitreq", 64'(waitreq), 64'(2'b11));
    check("full_m_read", 64'(m_read), 64'd0);
    tick();
    wr = 2'b10;
    @(negedge clk);
    check("full_wr_waitreq", 64'(waitreq), 64'(2'b01));
    check("full_wr_m_write", 64'(m_write), 64'd1);
    tick();
    wr = 2'b00;
    // Full still blocks the read in the cycle a beat pops the FIFO.
    m_rdv = 1'b1; m_rdata = 64'hE0;
    @(negedge clk);
    check("full_pop_waitreq", 64'(waitreq), 64'(2'b11));
    check("full_pop_rsp", 64'(rdv_out), 64'(exp_q.size() > 0 ? exp_q.pop_front() : 2'b00));
    tick();
    m_rdv = 1'b0;
    @(negedge clk);
    check("refill_waitreq", 64'(waitreq), 64'(2'b10));
    push_beats(0, 1);
    tick();
    rd = 2'b00;
    for (int k = 0; k < 16; k++) beat("drain_rsp", 64'hE1 + 64'(k));

    // Reset in the middle of a 4-beat write, then an orphan read beat.
    wr = 2'b01; bc = {6'd1, 6'd4};
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check("mid_wb_waitreq", 64'(waitreq), 64'(2'b10));
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_m_write", 64'(m_write), 64'd0);
    check("mid_rst_waitreq", 64'(waitreq), 64'(2'b11));
    tick();
    rst = 1'b0; wr = 2'b00;
    beat("orphan_rsp", 64'hF0);
    rd = 2'b11; bc = {6'd1, 6'd1};
    @(negedge clk);
    check("orphan_err", 64'(rsp_err), 64'd1);
    check("post_rst_waitreq", 64'(waitreq), 64'(2'b10));
    check("post_rst_m_read", 64'(m_read), 64'd1);
    push_beats(0, 1);
    tick();
    rd = 2'b00;
    beat("post_rst_rsp", 64'hF1);
    check("err_sticky", 64'(rsp_err), 64'd1);

`ifdef ASP_HOSTMEM_ARB_PERF_CNT_EN
    // Five req0 reads and three req1 single-beat writes after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd = 2'b01;
    for (int k = 0; k < 5; k++) begin
      push_beats(0, 1);
      tick();
    end
    rd = 2'b00; wr = 2'b10;
    for (int k = 0; k < 3; k++) tick();
    wr = 2'b00;
    @(negedge clk);
    check("grant_count", 64'(grant_count), {32'd3, 32'd5});
    tick();
    for (int k = 0; k < 5; k++) beat("perf_rsp", 64'h50 + 64'(k));
`endif

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
